// File: rtl/cosine_pkg.sv
// Shared types and widths for the cosine similarity front-end and datapath.
// Loader FSM state encoding lives here so benches and debug views agree on it.
package cosine_pkg;

  localparam int COS_DW        = 32;
  localparam int COS_W_DEFAULT = 5;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } loader_state_t;

endpackage

// File: rtl/cosine_vec_loader.sv
// Packs a valid/ready word stream into the A/B banks for cosine_sim, pulses start, then holds
// the similarity for a valid/ready drain; one beat per cycle, s_ready low from START until drained.
module cosine_vec_loader
  import cosine_pkg::*;
#(
  parameter int W       = COS_W_DEFAULT,
  parameter int DW      = COS_DW,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DW-1:0]         s_data,
  output logic [W-1:0][DW-1:0]  vec_a,
  output logic [W-1:0][DW-1:0]  vec_b,
  output logic                  start,
  input  logic                  sim_valid,
  input  logic [DW-1:0]         sim_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DW-1:0]         res_data,
  output logic                  busy,
  output logic                  err
);

  localparam int IW = $clog2(W);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  loader_state_t state, state_nxt;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;
  logic          s_fire;
  logic          last_beat;
  logic          timeout;

  assign s_ready   = (state == LOAD_A) || (state == LOAD_B);
  assign start     = (state == START);
  assign busy      = (state != LOAD_A) || (idx != '0);
  assign s_fire    = s_valid && s_ready;
  assign last_beat = (idx == IDX_LAST);
  assign timeout   = (timer == T_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD_A;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_A: if (s_fire && last_beat) state_nxt = LOAD_B;
      LOAD_B: if (s_fire && last_beat) state_nxt = START;
      START:  state_nxt = WAIT;
      // A completion arriving on the timeout cycle still counts as a result.
      WAIT: begin
        if (sim_valid)    state_nxt = RESULT;
        else if (timeout) state_nxt = LOAD_A;
      end
      RESULT: if (res_ready) state_nxt = LOAD_A;
      default: state_nxt = LOAD_A;
    endcase
    if (clear) state_nxt = LOAD_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      timer     <= '0;
      vec_a     <= '0;
      vec_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      err       <= 1'b0;
    end else if (clear) begin
      // Banks deliberately survive an abort; only control state is dropped.
      idx       <= '0;
      timer     <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        LOAD_A: if (s_fire) begin
          vec_a[idx] <= s_data;
          idx        <= last_beat ? '0 : idx + IW'(1);
        end
        LOAD_B: if (s_fire) begin
          vec_b[idx] <= s_data;
          idx        <= last_beat ? '0 : idx + IW'(1);
        end
        START: timer <= '0;
        WAIT: begin
          timer <= timer + TW'(1);
          if (sim_valid) begin
            res_data  <= sim_result;
            res_valid <= 1'b1;
          end else if (timeout) begin
            err <= 1'b1;
          end
        end
        RESULT: if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cosine_vec_loader.sv
// Bench for cosine_vec_loader: directed table, hand-written corner sequences and random transactions.
module tb_cosine_vec_loader;
  import cosine_pkg::*;

  localparam int W  = COS_W_DEFAULT;
  localparam int DW = COS_DW;
  localparam int TO = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clear = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [DW-1:0]        s_data = '0;
  logic [W-1:0][DW-1:0] vec_a, vec_b;
  logic                 start;
  logic                 sim_valid = 1'b0;
  logic [DW-1:0]        sim_result = '0;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic [DW-1:0]        res_data;
  logic                 busy;
  logic                 err;

  int   checks = 0;
  int   errors = 0;
  logic err_exp = 1'b0;

  typedef struct {
    logic [W-1:0][DW-1:0] a;
    logic [W-1:0][DW-1:0] b;
    int                   vmode;   // 0 held high, 1 every other cycle, 2 random
    int                   lat;     // cycles after start that sim_valid arrives, 0 = never
    int                   rd;      // cycles res_ready is held low
    logic [DW-1:0]        res;
    logic                 exp_to;  // expected outcome: timeout instead of result
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  cosine_vec_loader #(.W(W), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .vec_a(vec_a), .vec_b(vec_b), .start(start),
    .sim_valid(sim_valid), .sim_result(sim_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_banks(input string nm, input logic [W-1:0][DW-1:0] a,
                           input logic [W-1:0][DW-1:0] b);
    for (int i = 0; i < W; i++) begin
      chk({nm, "_vec_a"}, 64'(vec_a[i]), 64'(a[i]));
      chk({nm, "_vec_b"}, 64'(vec_b[i]), 64'(b[i]));
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    err_exp = 1'b0;
    chk("clear_busy", 64'(busy), 64'(0));
    chk("clear_err", 64'(err), 64'(0));
    chk("clear_res_valid", 64'(res_valid), 64'(0));
    chk("clear_s_ready", 64'(s_ready), 64'(1));
  endtask

  // Offers A then B words; stops after n accepted beats.
  task automatic load(input logic [W-1:0][DW-1:0] a, input logic [W-1:0][DW-1:0] b,
                      input int vmode, input int n, output bit ok);
    int k = 0;
    int cyc = 0;
    int starts = 0;
    bit fire;
    while (k < n && cyc < 400) begin
      case (vmode)
        0:       s_valid = 1'b1;
        1:       s_valid = (cyc % 2 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = (k < W) ? a[k] : b[k - W];
      fire = s_valid && s_ready;
      if (start) starts++;
      step();
      cyc++;
      if (fire) k++;
    end
    s_valid = 1'b0;
    chk("load_beats", 64'(k), 64'(n));
    chk("load_no_start", 64'(starts), 64'(0));
    if (vmode == 0) chk("load_cycles", 64'(cyc), 64'(n));
    ok = (k == n);
  endtask

  task automatic txn(input vec_t v);
    bit ok;
    int c = 0;
    load(v.a, v.b, v.vmode, 2 * W, ok);
    if (!ok) return;
    chk("start_pulse", 64'(start), 64'(1));
    chk("start_s_ready", 64'(s_ready), 64'(0));
    chk_banks("loaded", v.a, v.b);
    forever begin
      step();
      c++;
      chk("wait_start", 64'(start), 64'(0));
      chk("wait_s_ready", 64'(s_ready), 64'(0));
      chk("wait_err", 64'(err), 64'(err_exp));
      if (v.lat != 0 && c == v.lat) begin
        sim_valid = 1'b1;
        sim_result = v.res;
        step();
        sim_valid = 1'b0;
        sim_result = $urandom();
        break;
      end
      if (c >= TO) begin
        step();
        break;
      end
    end
    chk_banks("held", v.a, v.b);
    if (v.exp_to) begin
      err_exp = 1'b1;
      chk("to_err", 64'(err), 64'(1));
      chk("to_res_valid", 64'(res_valid), 64'(0));
      chk("to_busy", 64'(busy), 64'(0));
      chk("to_s_ready", 64'(s_ready), 64'(1));
    end else begin
      chk("res_valid", 64'(res_valid), 64'(1));
      chk("res_data", 64'(res_data), 64'(v.res));
      chk("res_err", 64'(err), 64'(err_exp));
      for (int i = 0; i < v.rd; i++) begin
        step();
        chk("res_hold_valid", 64'(res_valid), 64'(1));
        chk("res_hold_data", 64'(res_data), 64'(v.res));
        chk("res_hold_s_ready", 64'(s_ready), 64'(0));
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("drain_valid", 64'(res_valid), 64'(0));
      chk("drain_busy", 64'(busy), 64'(0));
      chk("drain_s_ready", 64'(s_ready), 64'(1));
    end
  endtask

  initial begin
    bit ok;
    vec_t v;
    logic [W-1:0][DW-1:0] ra, rb;

    tbl[0] = '{a: {32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, b: {32'd1, 32'd2, 32'd3, 32'd4, 32'd5},
               vmode: 0, lat: 6, rd: 5, res: 32'h0000_B6DB, exp_to: 1'b0};
    tbl[1] = '{a: {32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, b: {32'd1, 32'd2, 32'd3, 32'd4, 32'd5},
               vmode: 1, lat: 3, rd: 0, res: 32'h1234_5678, exp_to: 1'b0};
    tbl[2] = '{a: {32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, b: {32'd1, 32'd2, 32'd3, 32'd4, 32'd5},
               vmode: 0, lat: 0, rd: 0, res: 32'h0, exp_to: 1'b1};
    tbl[3] = '{a: {32'hFFFF_FFFF, 32'h0, 32'h8000_0001, 32'hA5A5_5A5A, 32'h7FFF_FFFF},
               b: {32'h0000_0001, 32'hFFFF_FFFE, 32'h0, 32'hC3C3_3C3C, 32'h8000_0000},
               vmode: 2, lat: TO, rd: 1, res: 32'hDEAD_BEEF, exp_to: 1'b0};
    tbl[4] = '{a: {32'd9, 32'd8, 32'd7, 32'd6, 32'd5}, b: {32'd4, 32'd3, 32'd2, 32'd1, 32'd0},
               vmode: 2, lat: TO + 1, rd: 0, res: 32'h5555_AAAA, exp_to: 1'b1};

    step();
    step();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_start", 64'(start), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_res_data", 64'(res_data), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(1));
    chk_banks("rst", '0, '0);
    rst_n = 1'b1;
    step();

    // sim_valid while idle must not produce a result
    sim_valid = 1'b1;
    sim_result = 32'hCAFE_F00D;
    step();
    sim_valid = 1'b0;
    chk("idle_sim_ignored", 64'(res_valid), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));

    for (int t = 0; t < 5; t++) begin
      txn(tbl[t]);
      if (tbl[t].exp_to) pulse_clear();
    end

    // abort after 7 beats, then a clean reload
    load(tbl[3].a, tbl[3].b, 0, 7, ok);
    chk("mid_load_busy", 64'(busy), 64'(1));
    pulse_clear();
    txn(tbl[0]);

    // clear during WAIT, followed by a late completion
    load(tbl[1].a, tbl[1].b, 0, 2 * W, ok);
    step();
    step();
    pulse_clear();
    sim_valid = 1'b1;
    sim_result = 32'h0BAD_0BAD;
    step();
    sim_valid = 1'b0;
    chk("late_sim_res_valid", 64'(res_valid), 64'(0));
    chk("late_sim_busy", 64'(busy), 64'(0));
    chk_banks("after_clear", tbl[1].a, tbl[1].b);

    // async reset during WAIT with err sticky from a prior timeout
    txn(tbl[2]);
    load(tbl[3].a, tbl[3].b, 0, 2 * W, ok);
    step();
    chk("pre_rst_err", 64'(err), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    err_exp = 1'b0;
    chk("arst_start", 64'(start), 64'(0));
    chk("arst_res_valid", 64'(res_valid), 64'(0));
    chk("arst_err", 64'(err), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk_banks("arst", '0, '0);
    rst_n = 1'b1;
    step();

    // random transactions against the transaction-level expectations
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < W; i++) begin
        ra[i] = $urandom();
        rb[i] = $urandom();
      end
      v.a = ra;
      v.b = rb;
      v.vmode = 2;
      v.lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO + 4));
      v.rd = $urandom_range(0, 3);
      v.res = $urandom();
      v.exp_to = (v.lat == 0) || (v.lat > TO);
      txn(v);
      if ($urandom_range(0, 1) == 1) pulse_clear();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
